tpg_multi: RTL and testbench
============================

# tpg_multi

Parametrised multi-mode test pattern generator for the LBIST datapath: the next generation of `tpg`. It emits a programmable-length run of patterns in exhaustive-counter, maximal-length LFSR or walking-one mode from a loadable seed. It supports stall via `hold` and flags completion with `END`. It drives the CUT inputs and the response compactor in the BIST wrapper.

## Interface
- `BITS`, 8: pattern width (≥2).
- `TAPS`, 8'hB8: Fibonacci feedback mask, `BITS` wide; bit i set = `TEST_PATTERN[i]` feeds the XOR.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `start` in 1: one-cycle run request.
- `mode` in 2: 00 counter, 01 LFSR, 10 walking-one, 11 treated as 00.
- `seed` in BITS: first pattern (counter/LFSR).
- `num_patterns` in BITS: patterns to apply; 0 = full mode period.
- `hold` in 1: stall; pattern frozen, not counted.
- `TEST_PATTERN` out BITS: current pattern (registered).
- `VALID` out 1: pattern is being applied this cycle = `BUSY & ~hold` (combinational).
- `BUSY` out 1: run in progress (registered).
- `END` out 1: run complete, sticky until next `start` or `rst` (registered).

## Operation
- States: IDLE (reset), RUN, DONE.
- IDLE/DONE + `start`=1 → RUN. On that edge:
  - latch `mode` and target T (T = `num_patterns`, or full period if 0);
  - load first pattern; clear applied-count C (BITS+1 bits); `END`←0, `BUSY`←1.
- `mode`, `seed`, `num_patterns` are sampled only at start; later changes are ignored until the next run.
- First pattern by mode:
  - counter: `seed`.
  - LFSR: `seed`, but all-zero seed is replaced by 1 (lock-up avoidance).
  - walking-one: 1 (seed ignored).
- Full period: counter 2^BITS, LFSR 2^BITS−1 (maximal `TAPS` is the integrator's responsibility), walking-one BITS.
- Advance rules, applied on each RUN cycle with `hold`=0:
  - counter: P+1 mod 2^BITS (wraps).
  - LFSR: {P[BITS-2:0], ^(P & TAPS)}.
  - walking-one: rotate left by 1.
- Counting and termination:
  - Each RUN cycle with `hold`=0 applies one pattern: C←C+1.
  - If C==T−1 on an applying cycle → DONE: `BUSY`←0, `END`←1, `TEST_PATTERN` keeps the last applied pattern.
  - Otherwise the pattern advances.
- `hold`=1 in RUN: pattern, C and state unchanged; `VALID`=0.
- `start` while in RUN is ignored.
- `rst`=1 has priority over everything, in any state.
- Num_patterns > full period: the sequence repeats from its first pattern (counter/walking-one wrap naturally; LFSR cycles).

## Timing
- Reset values: `TEST_PATTERN`=0, `BUSY`=0, `END`=0, `VALID`=0; state IDLE; C=0.
- Latency: first pattern is visible the cycle after the `start` edge, with `VALID`=1 if `hold`=0.
- A run of T patterns with no hold lasts exactly T cycles of `BUSY`=1. `END` rises on the edge after the last applying cycle.
- `start` in DONE restarts on that edge: `END` drops the same cycle `BUSY` rises; there is no idle gap.
- `start` and `hold` asserted together: the run starts normally. The first pattern is presented but not counted until `hold` falls.
- `rst` mid-run: on the next edge all outputs return to reset values and the state goes to IDLE. A `start` in the same cycle is ignored.
- T=1: one applying cycle, then DONE.

## Test plan
- BITS=3, TAPS=3'b110, mode=01, seed=001, num=0, start → `TEST_PATTERN` 001,010,101,011,111,110,100 on 7 consecutive `VALID` cycles, then `END`=1, `BUSY`=0, pattern held at 100.
- BITS=3, mode=00, seed=101, num=0 → 101,110,111,000,001,010,011,100 (8 cycles), then `END`; LFSR mode with seed=000 starts at 001.
- BITS=3, mode=10, num=4 → 001,010,100,001, then `END`; `seed`=111 has no effect.
- Counter, seed=0, num=5, `hold` high for 3 cycles after the second pattern → the pattern stays 001 with `VALID`=0 for those 3 cycles; total `BUSY`=8 cycles; `END` after 100.
- `rst` for 1 cycle mid-LFSR run → all outputs 0 next cycle, IDLE. New start with num=2 → 2 patterns, then `END`. `start` pulsed during RUN → no restart.
- Back-to-back: `start` in the cycle `END`=1 → `END`=0, `BUSY`=1 on the next edge, with the new first pattern.

Source files
------------

// File: rtl/tpg_multi_if.sv
// Handshake/bus bundle for the multi-mode test pattern generator.
// The master drives run requests and stall, the slave (generator) drives patterns and status.
interface tpg_multi_if #(
    parameter int BITS = 8
);
    logic            start;
    logic [1:0]      mode;
    logic [BITS-1:0] seed;
    logic [BITS-1:0] num_patterns;
    logic            hold;
    logic [BITS-1:0] TEST_PATTERN;
    logic            VALID;
    logic            BUSY;
    logic            END;

    modport master (
        output start, mode, seed, num_patterns, hold,
        input  TEST_PATTERN, VALID, BUSY, END
    );

    modport slave (
        input  start, mode, seed, num_patterns, hold,
        output TEST_PATTERN, VALID, BUSY, END
    );
endinterface

// File: rtl/tpg_multi.sv
// Multi-mode LBIST pattern generator: counter, Fibonacci LFSR or walking-one runs
// of programmable length, with stall via hold and a sticky completion flag.
module tpg_multi #(
    parameter int              BITS = 8,
    parameter logic [BITS-1:0] TAPS = 8'hB8
) (
    input logic        clk,
    input logic        rst,
    tpg_multi_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    typedef enum logic [1:0] {M_CNT, M_LFSR, M_WALK} mode_t;

    localparam logic [BITS:0] PERIOD_CNT  = {1'b1, {BITS{1'b0}}};
    localparam logic [BITS:0] PERIOD_LFSR = {1'b0, {BITS{1'b1}}};
    localparam logic [BITS:0] PERIOD_WALK = (BITS+1)'(BITS);
    localparam logic [BITS:0] ONE         = (BITS+1)'(1);

    state_t          state;
    mode_t           run_mode;
    logic [BITS-1:0] pattern;
    logic [BITS:0]   count;
    logic [BITS:0]   target;
    logic            busy;
    logic            end_flag;

    function automatic mode_t decode_mode(input logic [1:0] m);
        case (m)
            2'b01:   return M_LFSR;
            2'b10:   return M_WALK;
            default: return M_CNT;
        endcase
    endfunction

    function automatic logic [BITS-1:0] first_pattern(input mode_t m, input logic [BITS-1:0] s);
        case (m)
            // An all-zero LFSR state never leaves zero, so substitute 1.
            M_LFSR:  return (s == '0) ? BITS'(1) : s;
            M_WALK:  return BITS'(1);
            default: return s;
        endcase
    endfunction

    function automatic logic [BITS:0] full_period(input mode_t m);
        case (m)
            M_LFSR:  return PERIOD_LFSR;
            M_WALK:  return PERIOD_WALK;
            default: return PERIOD_CNT;
        endcase
    endfunction

    function automatic logic [BITS-1:0] next_pattern(input mode_t m, input logic [BITS-1:0] p);
        case (m)
            M_LFSR:  return {p[BITS-2:0], ^(p & TAPS)};
            M_WALK:  return {p[BITS-2:0], p[BITS-1]};
            default: return p + BITS'(1);
        endcase
    endfunction

    // NOTE: reset is tested first inside the clocked block, so it is synchronous and overrides start/hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            run_mode <= M_CNT;
            pattern  <= '0;
            count    <= '0;
            target   <= '0;
            busy     <= 1'b0;
            end_flag <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register sees pre-edge values of the others.
            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        state    <= RUN;
                        run_mode <= decode_mode(bus.mode);
                        pattern  <= first_pattern(decode_mode(bus.mode), bus.seed);
                        target   <= (bus.num_patterns == '0) ? full_period(decode_mode(bus.mode))
                                                             : {1'b0, bus.num_patterns};
                        count    <= '0;
                        busy     <= 1'b1;
                        end_flag <= 1'b0;
                    end
                end
                RUN: begin
                    if (!bus.hold) begin
                        count <= count + ONE;
                        if (count == target - ONE) begin
                            state    <= DONE;
                            busy     <= 1'b0;
                            end_flag <= 1'b1;
                        end else begin
                            pattern <= next_pattern(run_mode, pattern);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.TEST_PATTERN = pattern;
    assign bus.BUSY         = busy;
    assign bus.END          = end_flag;
    assign bus.VALID        = busy & ~bus.hold;
endmodule

// File: tb/tb_tpg_multi.sv
// Scoreboard bench for tpg_multi at BITS=3, TAPS=3'b110: expected patterns are queued
// when a run is requested and popped on every VALID cycle.
module tb_tpg_multi;
    localparam int BITS = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;
    logic [BITS-1:0] exp_q[$];

    tpg_multi_if #(.BITS(BITS)) bus ();

    tpg_multi #(.BITS(BITS), .TAPS(3'b110)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [BITS-1:0] v);
        exp_q.push_back(v);
    endtask

    task automatic start_run(input logic [1:0] m, input logic [BITS-1:0] s, input logic [BITS-1:0] n);
        bus.mode = m;
        bus.seed = s;
        bus.num_patterns = n;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
    endtask

    // Runs until END, popping the scoreboard on VALID; optionally stalls or pokes start mid-run.
    task automatic collect(input string name, input int exp_busy, input int hold_at,
                           input int hold_len, input bit poke_start);
        int busy_cycles = 0;
        int valid_seen = 0;
        int held = 0;
        int cyc = 0;
        bit finished = 0;
        logic [BITS-1:0] last = '0;
        logic [BITS-1:0] e;
        while (!finished && cyc < 100) begin
            bus.hold = (valid_seen == hold_at) && (held < hold_len);
            bus.start = poke_start && (cyc == 1);
            if (poke_start && cyc == 1) begin
                bus.mode = 2'b10;
                bus.seed = 3'd5;
                bus.num_patterns = 3'd1;
            end
            #1;
            if (bus.END === 1'b1) begin
                finished = 1;
            end else begin
                if (bus.BUSY === 1'b1) busy_cycles++;
                if (bus.hold) begin
                    held++;
                    total++;
                    if (bus.VALID !== 1'b0) begin
                        bad++;
                        $display("FAIL %s hold_valid: got %b expected 0", name, bus.VALID);
                    end
                    if (exp_q.size() > 0) begin
                        total++;
                        if (bus.TEST_PATTERN !== exp_q[0]) begin
                            bad++;
                            $display("FAIL %s hold_pattern: got %b expected %b", name, bus.TEST_PATTERN, exp_q[0]);
                        end
                    end
                end else if (bus.VALID === 1'b1) begin
                    total++;
                    if (exp_q.size() == 0) begin
                        bad++;
                        $display("FAIL %s extra_pattern: got %b expected none", name, bus.TEST_PATTERN);
                    end else begin
                        e = exp_q.pop_front();
                        if (bus.TEST_PATTERN !== e) begin
                            bad++;
                            $display("FAIL %s pattern[%0d]: got %b expected %b", name, valid_seen, bus.TEST_PATTERN, e);
                        end
                    end
                    last = bus.TEST_PATTERN;
                    valid_seen++;
                end
                step();
                cyc++;
            end
        end
        bus.hold = 1'b0;
        bus.start = 1'b0;
        total++;
        if (!finished) begin
            bad++;
            $display("FAIL %s timeout: got no END after %0d cycles expected END", name, cyc);
        end
        total++;
        if (busy_cycles != exp_busy) begin
            bad++;
            $display("FAIL %s busy_cycles: got %0d expected %0d", name, busy_cycles, exp_busy);
        end
        total++;
        if (bus.BUSY !== 1'b0 || bus.VALID !== 1'b0) begin
            bad++;
            $display("FAIL %s busy_after_end: got BUSY=%b VALID=%b expected 0 0", name, bus.BUSY, bus.VALID);
        end
        total++;
        if (bus.TEST_PATTERN !== last) begin
            bad++;
            $display("FAIL %s held_last: got %b expected %b", name, bus.TEST_PATTERN, last);
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL %s leftover: got %0d unconsumed expected 0", name, exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic check_idle_outputs(input string name);
        total++;
        if (bus.TEST_PATTERN !== '0 || bus.BUSY !== 1'b0 || bus.END !== 1'b0 || bus.VALID !== 1'b0) begin
            bad++;
            $display("FAIL %s: got pat=%b busy=%b end=%b valid=%b expected 000 0 0 0",
                     name, bus.TEST_PATTERN, bus.BUSY, bus.END, bus.VALID);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.start = 1'b1;
        step();
        step();
        check_idle_outputs("reset_values");
        bus.start = 1'b0;
        rst = 1'b0;
        step();
        check_idle_outputs("idle_after_reset");
    endtask

    task automatic test_lfsr();
        logic [BITS-1:0] seq[7] = '{3'b001, 3'b010, 3'b101, 3'b011, 3'b111, 3'b110, 3'b100};
        foreach (seq[i]) push(seq[i]);
        start_run(2'b01, 3'b001, 3'd0);
        collect("lfsr_full", 7, -1, 0, 0);
        push(3'b001); push(3'b010); push(3'b101);
        start_run(2'b01, 3'b000, 3'd3);
        collect("lfsr_zero_seed", 3, -1, 0, 0);
    endtask

    task automatic test_counter();
        for (int i = 0; i < 8; i++) push(3'(5 + i));
        start_run(2'b00, 3'b101, 3'd0);
        collect("counter_full", 8, -1, 0, 0);
        push(3'b011); push(3'b100);
        start_run(2'b11, 3'b011, 3'd2);
        collect("mode11_counter", 2, -1, 0, 0);
        push(3'b111);
        start_run(2'b00, 3'b111, 3'd1);
        collect("single_pattern", 1, -1, 0, 0);
    endtask

    task automatic test_walking();
        push(3'b001); push(3'b010); push(3'b100); push(3'b001);
        start_run(2'b10, 3'b111, 3'd4);
        collect("walk_num4", 4, -1, 0, 0);
        push(3'b001); push(3'b010); push(3'b100); push(3'b001); push(3'b010);
        start_run(2'b10, 3'b000, 3'd5);
        collect("walk_wrap", 5, -1, 0, 0);
    endtask

    task automatic test_hold();
        for (int i = 0; i < 5; i++) push(3'(i));
        start_run(2'b00, 3'b000, 3'd5);
        collect("hold_mid", 8, 1, 3, 0);
        push(3'b110); push(3'b111);
        start_run(2'b00, 3'b110, 3'd2);
        collect("hold_at_start", 4, 0, 2, 0);
    endtask

    task automatic test_reset_mid_run();
        start_run(2'b01, 3'b001, 3'd0);
        step();
        step();
        rst = 1'b1;
        bus.start = 1'b1;
        step();
        rst = 1'b0;
        bus.start = 1'b0;
        check_idle_outputs("reset_mid_run");
        step();
        check_idle_outputs("start_with_reset_ignored");
        push(3'b001); push(3'b010);
        start_run(2'b01, 3'b001, 3'd2);
        collect("after_reset_num2", 2, -1, 0, 0);
        push(3'b000); push(3'b001); push(3'b010);
        start_run(2'b00, 3'b000, 3'd3);
        collect("start_in_run_ignored", 3, -1, 0, 1);
    endtask

    task automatic test_back_to_back();
        push(3'b100); push(3'b101);
        start_run(2'b00, 3'b100, 3'd2);
        collect("b2b_first", 2, -1, 0, 0);
        total++;
        if (bus.END !== 1'b1) begin
            bad++;
            $display("FAIL b2b_end_before: got %b expected 1", bus.END);
        end
        push(3'b001); push(3'b010); push(3'b100);
        start_run(2'b10, 3'b000, 3'd3);
        total++;
        if (bus.END !== 1'b0 || bus.BUSY !== 1'b1 || bus.TEST_PATTERN !== 3'b001) begin
            bad++;
            $display("FAIL b2b_restart: got end=%b busy=%b pat=%b expected 0 1 001",
                     bus.END, bus.BUSY, bus.TEST_PATTERN);
        end
        collect("b2b_second", 3, -1, 0, 0);
    endtask

    initial begin
        bus.start = 1'b0;
        bus.mode = 2'b00;
        bus.seed = '0;
        bus.num_patterns = '0;
        bus.hold = 1'b0;
        test_reset();
        test_lfsr();
        test_counter();
        test_walking();
        test_hold();
        test_reset_mid_run();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running expected finish");
        $fatal(1, "watchdog expired");
    end
endmodule
